// File: rtl/mod_button_events.sv
// mod_button_events: classifies a debounced button level into press/release
// edges and resolved gestures (single short click, double click, long press).
//
// Parameters:
//   LONG_CYCLES - hold length (clk_i cycles) that qualifies a long press (>= 2)
//   GAP_CYCLES  - max release-to-press gap (clk_i cycles) for a double click (>= 2)
// Ports:
//   clk_i      - clock, rising edge
//   rst_n_i    - synchronous active-low reset
//   btn_i      - debounced button level, 1 = pressed
//   held_o     - registered button level
//   press_o    - one-cycle pulse per press
//   release_o  - one-cycle pulse per release
//   short_o    - one-cycle pulse for a resolved single short click
//   double_o   - one-cycle pulse for a resolved double click
//   long_o     - one-cycle pulse when a hold reaches LONG_CYCLES
module mod_button_events #(
    parameter int unsigned LONG_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES  = 250
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic held_o,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic double_o,
    output logic long_o
);

    localparam int unsigned MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DOWN1 = 3'd1,
        S_GAP   = 3'd2,
        S_DOWN2 = 3'd3,
        S_LONG  = 3'd4
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             btn_q;
    logic             press_q;
    logic             release_q;
    logic             short_q;
    logic             double_q;
    logic             long_q;

    logic rise_c;
    logic fall_c;
    logic long_hit_c;

    // Edge detection against the previous sampled level
    always_comb begin
        rise_c     = btn_i & ~btn_q;
        fall_c     = ~btn_i & btn_q;
        long_hit_c = btn_i & (cnt_q == LONG_LAST);
    end

    // Gesture FSM; counter restarts on every state entry and saturates otherwise
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            btn_q     <= btn_i;
            press_q   <= rise_c;
            release_q <= fall_c;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;

            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (rise_c) begin
                        state_q <= S_DOWN1;
                        cnt_q   <= '0;
                    end
                end
                S_DOWN1: begin
                    if (fall_c) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                    end else if (long_hit_c) begin
                        long_q  <= 1'b1;
                        state_q <= S_LONG;
                        cnt_q   <= '0;
                    end
                end
                S_GAP: begin
                    // A re-press on the timeout cycle still counts as a second click
                    if (rise_c) begin
                        state_q <= S_DOWN2;
                        cnt_q   <= '0;
                    end else if (cnt_q == GAP_LAST) begin
                        short_q <= 1'b1;
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                end
                S_DOWN2: begin
                    if (fall_c) begin
                        double_q <= 1'b1;
                        state_q  <= S_IDLE;
                        cnt_q    <= '0;
                    end else if (long_hit_c) begin
                        // Long hold on the second press discards the first click
                        long_q  <= 1'b1;
                        state_q <= S_LONG;
                        cnt_q   <= '0;
                    end
                end
                S_LONG: begin
                    if (fall_c) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign held_o    = btn_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign short_o   = short_q;
    assign double_o  = double_q;
    assign long_o    = long_q;

endmodule

// File: tb/tb_mod_button_events.sv
// tb_mod_button_events: directed gesture sequences with LONG_CYCLES=16, GAP_CYCLES=8.
module tb_mod_button_events;

    localparam int unsigned LONG_C = 16;
    localparam int unsigned GAP_C  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic held_o, press_o, release_o, short_o, double_o, long_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_press, n_release, n_short, n_double, n_long;
    int t_press, t_release, t_short, t_double, t_long;
    bit mon_en = 1'b0;

    mod_button_events #(
        .LONG_CYCLES(LONG_C),
        .GAP_CYCLES (GAP_C)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .btn_i    (btn),
        .held_o   (held_o),
        .press_o  (press_o),
        .release_o(release_o),
        .short_o  (short_o),
        .double_o (double_o),
        .long_o   (long_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts each output pulse and records the cycle it appeared
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (press_o)   begin n_press++;   t_press   = cyc; end
        if (release_o) begin n_release++; t_release = cyc; end
        if (short_o)   begin n_short++;   t_short   = cyc; end
        if (double_o)  begin n_double++;  t_double  = cyc; end
        if (long_o)    begin n_long++;    t_long    = cyc; end
        if (mon_en)
            chk("onehot", int'((int'(short_o) + int'(double_o) + int'(long_o)) <= 1), 1);
    end

    task automatic clr();
        n_press = 0; n_release = 0; n_short = 0; n_double = 0; n_long = 0;
        t_press = -1; t_release = -1; t_short = -1; t_double = -1; t_long = -1;
    endtask

    // Hold btn at v for n sampling edges; returns 2 time units after the last edge
    task automatic drive(input logic v, input int n);
        btn = v;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic int outs();
        return int'({held_o, press_o, release_o, short_o, double_o, long_o});
    endfunction

    int t0;

    initial begin
        clr();
        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 3);
        chk("reset_outs", outs(), 0);
        rst_n = 1'b1;
        drive(1'b0, 2);
        mon_en = 1'b1;

        // Single short click: short 8 cycles after release
        clr();
        drive(1'b1, 5);
        chk("short_held", int'(held_o), 1);
        drive(1'b0, 20);
        chk("short_np", n_press, 1);
        chk("short_nr", n_release, 1);
        chk("short_ns", n_short, 1);
        chk("short_lat", t_short - t_release, GAP_C);
        chk("short_nd", n_double, 0);
        chk("short_nl", n_long, 0);

        // Double click: double with second release
        clr();
        drive(1'b1, 4); drive(1'b0, 3); drive(1'b1, 4); drive(1'b0, 20);
        chk("dbl_nd", n_double, 1);
        chk("dbl_same", t_double, t_release);
        chk("dbl_ns", n_short, 0);
        chk("dbl_nr", n_release, 2);

        // Long press: long 16 cycles after press, release yields release only
        clr();
        drive(1'b1, 40);
        chk("long_nl", n_long, 1);
        chk("long_lat", t_long - t_press, LONG_C);
        drive(1'b0, 20);
        chk("long_nr", n_release, 1);
        chk("long_ns", n_short, 0);
        chk("long_nd", n_double, 0);
        // FSM back in IDLE: a fresh click resolves as short
        clr();
        drive(1'b1, 3); drive(1'b0, 20);
        chk("long_idle", n_short, 1);

        // Re-press on the GAP timeout cycle wins over timeout
        clr();
        drive(1'b1, 3); drive(1'b0, 8); drive(1'b1, 3); drive(1'b0, 20);
        chk("edge_ns", n_short, 0);
        chk("edge_nd", n_double, 1);

        // Re-press one cycle after timeout: two independent short clicks
        clr();
        drive(1'b1, 3); drive(1'b0, 9); drive(1'b1, 3); drive(1'b0, 20);
        chk("late_ns", n_short, 2);
        chk("late_nd", n_double, 0);
        chk("late_np", n_press, 2);

        // Reset mid-DOWN1 with button held
        drive(1'b1, 3);
        clr();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1);
            chk("rst_outs", outs(), 0);
        end
        chk("rst_pulses", n_press + n_release + n_short + n_double + n_long, 0);
        t0 = cyc;
        rst_n = 1'b1;
        drive(1'b1, 1);
        chk("rst_np", n_press, 1);
        chk("rst_tp", t_press, t0 + 1);
        drive(1'b0, 20);
        chk("rst_ns", n_short, 1);

        // Second press of a double click held long: long only
        clr();
        drive(1'b1, 4); drive(1'b0, 3); drive(1'b1, 20);
        chk("d2l_lat", t_long - t_press, LONG_C);
        drive(1'b0, 20);
        chk("d2l_nl", n_long, 1);
        chk("d2l_ns", n_short, 0);
        chk("d2l_nd", n_double, 0);

        // Third press after a double click starts a new sequence
        clr();
        drive(1'b1, 3); drive(1'b0, 3); drive(1'b1, 3); drive(1'b0, 3);
        drive(1'b1, 3); drive(1'b0, 20);
        chk("tri_nd", n_double, 1);
        chk("tri_ns", n_short, 1);
        chk("tri_np", n_press, 3);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
